mux_scan_ctrl: RTL and testbench

- Sequencer wrapped around the 4:1 buffer mux (mux_buf).
- Upstream role: drives the mux select s.
- Downstream role: samples the mux output y after a settle interval and packs the four channel bits into one nibble.
- Result is presented on a valid/ready handshake to the consumer.
- Converts the combinational mux into a scanned 4-bit input port.

---
 rtl/mux_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans a 4:1 buffer mux (mux_buf) into a 4-bit result.
// s steps 0..3. Each select value is held SETTLE_CYC+1 cycles, and y is
// sampled in the last of those cycles. The packed nibble is offered on a
// valid/ready handshake.
// Optional macro MUX_SCAN_CONT_EN: after each accepted result the scan
// restarts immediately (continuous mode) instead of returning to IDLE.
// Parameters: SETTLE_CYC in 1..15, CNT_W with 2**CNT_W > SETTLE_CYC.
module mux_scan_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic [1:0] s,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [1:0]       s_nxt_s;
  logic             busy_nxt_s;
  logic             valid_nxt_s;
  logic [3:0]       data_nxt_s;
  logic             handshake_s;

  assign handshake_s = valid & ready;

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      s       <= 2'd0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      data    <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      s       <= s_nxt_s;
      busy    <= busy_nxt_s;
      valid   <= valid_nxt_s;
      data    <= data_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = SAMPLE;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      SAMPLE: begin
        if (s == 2'd3) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      DONE: begin
        if (handshake_s) begin
`ifdef MUX_SCAN_CONT_EN
          state_nxt_s = SETTLE;
`else
          state_nxt_s = IDLE;
`endif
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the settle counter.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    s_nxt_s     = s;
    busy_nxt_s  = busy;
    valid_nxt_s = valid;
    data_nxt_s  = data;
    case (state_r)
      IDLE: begin
        s_nxt_s     = 2'd0;
        valid_nxt_s = 1'b0;
        if (start) begin
          busy_nxt_s = 1'b1;
          cnt_nxt_s  = CNT_RELOAD;
        end else begin
          busy_nxt_s = 1'b0;
          cnt_nxt_s  = cnt_r;
        end
      end
      SETTLE: begin
        // The counter parks at zero; the state change is what ends SETTLE.
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      SAMPLE: begin
        data_nxt_s[s] = y;
        if (s != 2'd3) begin
          s_nxt_s   = s + 2'd1;
          cnt_nxt_s = CNT_RELOAD;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      DONE: begin
        if (handshake_s) begin
          valid_nxt_s = 1'b0;
          s_nxt_s     = 2'd0;
`ifdef MUX_SCAN_CONT_EN
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = CNT_RELOAD;
`else
          busy_nxt_s  = 1'b0;
`endif
        end else begin
          valid_nxt_s = valid;
        end
      end
      default: begin
        s_nxt_s     = 2'd0;
        busy_nxt_s  = 1'b0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl. A behavioural 4:1 mux drives y from mux_in[s].
// Expected results are queued when a scan is started. A negedge monitor pops
// one entry on every rising valid and checks the data and the edge it rose on.
// Set MUX_SCAN_CONT_EN to run the continuous-mode test.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       y;
  logic [1:0] s;
  logic       busy;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic [3:0] mux_in;

  int checks;
  int errors;
  int cyc;
  int e0;

  typedef struct {
    logic [3:0] d;
    int         c;
  } exp_t;
  exp_t exp_q[$];

  mux_scan_ctrl #(.SETTLE_CYC(2), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y     (y),
    .s     (s),
    .busy  (busy),
    .data  (data),
    .valid (valid),
    .ready (ready)
  );

  assign y = mux_in[s];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; e0 becomes the index of the edge that sampled it.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic push_exp(input logic [3:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising valid must match the head of the queue.
  initial begin
    logic valid_prev;
    exp_t e;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && valid_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got data %0h at edge %0d, expected no result", data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result_data", {28'd0, data}, {28'd0, e.d});
          chk("result_edge", cyc, e.c);
          chk("result_s", {30'd0, s}, 32'd3);
        end
      end
      valid_prev = valid;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    ready  = 1'b0;
    mux_in = 4'b0000;
    e0     = 0;
    wait_edges(2);
    chk("reset_s", {30'd0, s}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_data", {28'd0, data}, 32'd0);
    rst_n = 1'b1;
    wait_edges(2);

`ifndef MUX_SCAN_CONT_EN
    // Basic scan: s walks 0,1,2,3 at E0,E3,E6,E9; result at E12; handshake E13.
    ready  = 1'b1;
    mux_in = 4'b1010;
    do_start();
    push_exp(4'b1010, e0 + 12);
    chk("basic_busy_e0", {31'd0, busy}, 32'd1);
    for (int ch = 0; ch < 4; ch++) begin
      chk("basic_s_step", {30'd0, s}, ch);
      wait_edges(3);
    end
    chk("basic_valid_e12", {31'd0, valid}, 32'd1);
    chk("basic_busy_e12", {31'd0, busy}, 32'd1);
    wait_edges(1);
    chk("basic_valid_e13", {31'd0, valid}, 32'd0);
    chk("basic_busy_e13", {31'd0, busy}, 32'd0);
    chk("basic_s_e13", {30'd0, s}, 32'd0);
    wait_edges(2);

    // Backpressure: ready low for 5 cycles after valid.
    ready = 1'b0;
    do_start();
    push_exp(4'b1010, e0 + 12);
    wait_edges(12);
    chk("bp_valid_e12", {31'd0, valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_edges(1);
      chk("bp_valid_hold", {31'd0, valid}, 32'd1);
      chk("bp_data_hold", {28'd0, data}, 32'h0000000a);
      chk("bp_s_hold", {30'd0, s}, 32'd3);
    end
    ready = 1'b1;
    wait_edges(1);
    chk("bp_valid_after", {31'd0, valid}, 32'd0);
    chk("bp_busy_after", {31'd0, busy}, 32'd0);
    wait_edges(2);

    // Ignored start pulses at E4 and on the handshake edge E13.
    mux_in = 4'b0101;
    do_start();
    push_exp(4'b0101, e0 + 12);
    wait_edges(3);
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
    chk("ign_s_e4", {30'd0, s}, 32'd1);
    wait_edges(8);
    chk("ign_valid_e12", {31'd0, valid}, 32'd1);
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
    chk("ign_busy_e13", {31'd0, busy}, 32'd0);
    chk("ign_valid_e13", {31'd0, valid}, 32'd0);
    wait_edges(1);
    chk("ign_busy_e14", {31'd0, busy}, 32'd0);
    wait_edges(20);
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);

    // Input changes after channel 1 is sampled at E6.
    mux_in = 4'b0000;
    do_start();
    push_exp(4'b1100, e0 + 12);
    wait_edges(6);
    mux_in = 4'b1111;
    wait_edges(8);
    chk("chg_idle_busy", {31'd0, busy}, 32'd0);
    wait_edges(2);
`else
    // Continuous mode: results at E12, E25, E38; busy stays high.
    ready  = 1'b1;
    mux_in = 4'b0110;
    do_start();
    push_exp(4'b0110, e0 + 12);
    push_exp(4'b0110, e0 + 25);
    push_exp(4'b0110, e0 + 38);
    wait_edges(12);
    chk("cont_valid_e12", {31'd0, valid}, 32'd1);
    wait_edges(1);
    chk("cont_valid_e13", {31'd0, valid}, 32'd0);
    chk("cont_busy_e13", {31'd0, busy}, 32'd1);
    chk("cont_s_e13", {30'd0, s}, 32'd0);
    wait_edges(12);
    chk("cont_valid_e25", {31'd0, valid}, 32'd1);
    wait_edges(13);
    chk("cont_valid_e38", {31'd0, valid}, 32'd1);
    wait_edges(1);
    chk("cont_busy_e39", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    wait_edges(1);
    rst_n = 1'b1;
    chk("cont_rst_busy", {31'd0, busy}, 32'd0);
    chk("cont_rst_valid", {31'd0, valid}, 32'd0);
    wait_edges(30);
    chk("cont_stopped_busy", {31'd0, busy}, 32'd0);
`endif

    // Reset mid-scan while s==2; no result may appear afterwards.
    mux_in = 4'b1111;
    do_start();
    wait_edges(6);
    chk("rst_mid_s2", {30'd0, s}, 32'd2);
    rst_n = 1'b0;
    wait_edges(2);
    chk("rst_mid_s", {30'd0, s}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, valid}, 32'd0);
    chk("rst_mid_data", {28'd0, data}, 32'd0);
    rst_n = 1'b1;
    wait_edges(20);
    chk("rst_mid_after_valid", {31'd0, valid}, 32'd0);
    chk("rst_mid_after_busy", {31'd0, busy}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
